// File: rtl/pipe_adder_stage.sv
`default_nettype none
// pipe_adder_stage: one chunk of the carry chain plus its valid bit, sum-prefix and
// operand pass-through registers.  Rev 1.0
module pipe_adder_stage #(
   parameter int CHUNK  = 4,
   parameter int PASS_W = 0,
   parameter int PRE_W  = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_valid,
   output logic                               o_ready,
   input  logic [2*(CHUNK+PASS_W)+PRE_W-1:0]  i_data,
   input  logic                               i_cin,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic [2*PASS_W+PRE_W+CHUNK-1:0]    o_data,
   output logic                               o_cout
);
   // i_data = {a_rem, b_rem, sum_prefix}; the low CHUNK bits of each *_rem are added here.
   localparam int OP_W = CHUNK + PASS_W;

   logic [CHUNK-1:0]       w_a_ch;
   logic [CHUNK-1:0]       w_b_ch;
   logic [CHUNK:0]         w_add;
   logic                   w_load;
   logic                   r_valid;
   logic                   r_cout;
   logic [PRE_W+CHUNK-1:0] r_sum;

   assign w_a_ch  = i_data[PRE_W+OP_W +: CHUNK];
   assign w_b_ch  = i_data[PRE_W +: CHUNK];
   assign w_add   = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, i_cin};
   assign o_ready = !r_valid || i_ready;
   assign w_load  = i_valid && o_ready;
   assign o_valid = r_valid;
   assign o_cout  = r_cout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         if (w_load)
            r_valid <= 1'b1;
         else if (i_ready)
            r_valid <= 1'b0;
         if (w_load)
            r_cout <= w_add[CHUNK];
      end
   end

   if (PRE_W > 0) begin : g_pre
      always_ff @(posedge clk) begin
         if (rst)
            r_sum <= '0;
         else if (w_load)
            r_sum <= {w_add[CHUNK-1:0], i_data[PRE_W-1:0]};
      end
   end else begin : g_nopre
      always_ff @(posedge clk) begin
         if (rst)
            r_sum <= '0;
         else if (w_load)
            r_sum <= w_add[CHUNK-1:0];
      end
   end

   if (PASS_W > 0) begin : g_pass
      logic [PASS_W-1:0] r_a;
      logic [PASS_W-1:0] r_b;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_a <= '0;
            r_b <= '0;
         end else if (w_load) begin
            r_a <= i_data[PRE_W+OP_W+CHUNK +: PASS_W];
            r_b <= i_data[PRE_W+CHUNK +: PASS_W];
         end
      end
      assign o_data = {r_a, r_b, r_sum};
   end else begin : g_nopass
      assign o_data = r_sum;
   end
endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// pipe_adder: WIDTH-bit pipelined adder with cin/cout/signed overflow; the carry chain is
// split over STAGES registered chunks behind a bubble-collapsing valid/ready pipe.  Rev 1.0
module pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;
   localparam int LPRE  = LAST * CHUNK;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int PRE_W  = k * CHUNK;
      localparam int PASS_W = WIDTH - (k + 1) * CHUNK;
      localparam int IN_W   = 2 * (WIDTH - k * CHUNK) + PRE_W;
      localparam int OUT_W  = 2 * PASS_W + PRE_W + CHUNK;

      logic [IN_W-1:0]  w_din;
      logic [OUT_W-1:0] w_dout;
      logic             w_vin;
      logic             w_cin;
      logic             w_rin;
      logic             w_rdy;
      logic             w_v;
      logic             w_c;

      if (k == 0) begin : g_first
         assign w_din = {a, b};
         assign w_vin = in_valid;
         assign w_cin = cin;
      end else begin : g_mid
         assign w_din = g_stage[k-1].w_dout;
         assign w_vin = g_stage[k-1].w_v;
         assign w_cin = g_stage[k-1].w_c;
      end

      if (k == LAST) begin : g_tail
         assign w_rin = out_ready;
      end else begin : g_link
         assign w_rin = g_stage[k+1].w_rdy;
      end

      pipe_adder_stage #(
         .CHUNK  (CHUNK),
         .PASS_W (PASS_W),
         .PRE_W  (PRE_W)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_valid (w_vin),
         .o_ready (w_rdy),
         .i_data  (w_din),
         .i_cin   (w_cin),
         .o_valid (w_v),
         .i_ready (w_rin),
         .o_data  (w_dout),
         .o_cout  (w_c)
      );
   end

   // Carry into the MSB, recomputed from the last stage's inputs and registered on its load.
   logic w_c_msb;
   logic w_last_load;
   logic r_c_msb;

   assign w_last_load = g_stage[LAST].w_vin && g_stage[LAST].w_rdy;

   if (CHUNK == 1) begin : g_c_one
      assign w_c_msb = g_stage[LAST].w_cin;
   end else begin : g_c_low
      logic [CHUNK-1:0] w_low;
      assign w_low   = {1'b0, g_stage[LAST].w_din[LPRE+CHUNK +: CHUNK-1]}
                     + {1'b0, g_stage[LAST].w_din[LPRE +: CHUNK-1]}
                     + {{(CHUNK-1){1'b0}}, g_stage[LAST].w_cin};
      assign w_c_msb = w_low[CHUNK-1];
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_c_msb <= 1'b0;
      else if (w_last_load)
         r_c_msb <= w_c_msb;
   end

   assign in_ready  = g_stage[0].w_rdy;
   assign out_valid = g_stage[LAST].w_v;
   assign sum       = g_stage[LAST].w_dout;
   assign cout      = g_stage[LAST].w_c;
   assign ovf       = r_c_msb ^ g_stage[LAST].w_c;
endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// tb_pipe_adder: random and directed stimulus with a scoreboard queue checked by an
// independent output monitor.  Rev 1.0
module tb_pipe_adder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_out = 0;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
      exp_t        m;
      int unsigned u;
      int          s;
      u   = int'(x) + int'(y) + int'(ci);
      s   = int'($signed(x)) + int'($signed(y)) + int'(ci);
      m.s = 16'(u % 65536);
      m.c = (u >= 65536);
      m.o = (s > 32767) || (s < -32768);
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
      end else begin
         if (in_valid && in_ready)
            q.push_back(model(a, b, cin));
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("sum", 32'(sum), 32'(e.s));
               chk("cout", 32'(cout), 32'(e.c));
               chk("ovf", 32'(ovf), 32'(e.o));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_lat(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
      int n;
      a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("lat_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'd4);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] va[6];
      logic [15:0] vb[6];
      logic        vc[6];
      logic [15:0] s0;
      logic        c0, o0, okrdy, acc, pend;
      int          idx, nout0, budget;

      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      tick();

      send_lat(16'hFFFF, 16'h0001, 1'b0);
      send_lat(16'hFFFF, 16'h0001, 1'b1);
      send_lat(16'h7FFF, 16'h0001, 1'b0);
      send_lat(16'h8000, 16'h8000, 1'b0);
      send_lat(16'h0FFF, 16'h0001, 1'b0);

      // Back-to-back random stream.
      out_ready = 1'b1; okrdy = 1'b1; nout0 = n_out;
      for (int i = 0; i < 100; i++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom % 2); in_valid = 1'b1;
         @(negedge clk);
         if (!in_ready) okrdy = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      chk("stream_in_ready", 32'(okrdy), 32'd1);
      chk("stream_count", 32'(n_out - nout0), 32'd100);
      chk("stream_q_empty", 32'(q.size()), 32'd0);

      // Backpressure: six offered with the consumer stalled.
      for (int i = 0; i < 6; i++) begin
         va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom % 2);
      end
      out_ready = 1'b0; idx = 0;
      for (int c = 0; c < 8; c++) begin
         if (idx < 6) begin
            a = va[idx]; b = vb[idx]; cin = vc[idx]; in_valid = 1'b1;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         tick();
      end
      @(negedge clk);
      chk("bp_accepted", 32'(idx), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      s0 = sum; c0 = cout; o0 = ovf;
      repeat (3) tick();
      @(negedge clk);
      chk("bp_sum_stable", 32'(sum), 32'(s0));
      chk("bp_cout_stable", 32'(cout), 32'(c0));
      chk("bp_ovf_stable", 32'(ovf), 32'(o0));
      tick();
      out_ready = 1'b1; budget = 0;
      while (idx < 6 && budget < 20) begin
         a = va[idx]; b = vb[idx]; cin = vc[idx]; in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) idx++;
         tick();
         budget++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'd6);
      repeat (8) tick();
      chk("bp_q_empty", 32'(q.size()), 32'd0);

      // Bubbles with random consumer stalls.
      pend = 1'b0;
      for (int c = 0; c < 120; c++) begin
         if (!pend && (c % 2 == 0)) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom % 2);
            in_valid = 1'b1; pend = 1'b1;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            in_valid = 1'b0; pend = 1'b0;
         end
         out_ready = 1'($urandom % 2);
      end
      budget = 0;
      while (in_valid && budget < 20) begin
         out_ready = 1'b1;
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) in_valid = 1'b0;
         budget++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) tick();
      chk("bubble_q_empty", 32'(q.size()), 32'd0);

      // Reset with three transactions in flight.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom % 2); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_out_valid", 32'(out_valid), 32'd0);
         tick();
      end
      chk("post_rst_q_empty", 32'(q.size()), 32'd0);
      send_lat(16'h1234, 16'h4321, 1'b1);
      repeat (2) tick();
      chk("final_q_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder with carry-in, carry-out and signed-overflow flag, generalising the team's 2-bit dataflow full adder to WIDTH bits. The carry chain is split into STAGES equal chunks, one chunk per register stage, so wide adds close timing at full clock rate. A valid/ready handshake on both sides lets the block sit between streaming producers and consumers, such as accumulator and ALU datapaths.

## Interface
- WIDTH, 16, operand and sum width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth and chunk count.
  - WIDTH mod STAGES == 0 and STAGES ≥ 1.
  - CHUNK = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock. One clock domain only.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a/b/cin present a transaction.
- in_ready  out  1  block accepts this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  sum/cout/ovf hold a result.
- out_ready  in  1  consumer accepts this cycle.
- sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow. Equals carry into the MSB XOR carry out of the MSB.

## Operation
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Stage k (0..STAGES-1) holds these registers:
  - a valid bit.
  - Sum bits [(k+1)·CHUNK-1:0], already computed.
  - The a/b bits above that range, not yet added.
  - The carry out of chunk k.
  - For the last stage only: the carry into bit WIDTH-1, registered alongside for ovf.
- Stage 0 computes chunk 0 from a, b and cin on input transfer. Stage k computes chunk k from its forwarded a/b bits and the carry held in stage k-1.
- Advance rule (bubble-collapsing):
  - Stage k loads when its upstream source is valid AND (stage k is empty OR stage k is unloading this cycle).
  - Stage k unloads when downstream is loading from it. For the last stage, that means an output transfer.
  - in_ready = stage 0 empty OR stage 0 unloading. in_ready is combinational from out_ready through the valid chain; this is acceptable.
- Output mapping: sum, cout and ovf are driven directly from last-stage registers. They are stable while out_valid && !out_ready.
- A stage whose valid bit is 0 holds its data registers unchanged. No X-propagation requirement applies to the data registers.
- STAGES == 1: the full add is computed in one stage and the result is registered.

## Timing
- Reset: all valid bits clear, so out_valid = 0 and in_ready = 1 in the first cycle after rst deasserts. sum, cout and ovf reset to 0.
- Latency: STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: one transaction per cycle while out_ready is held high.
- Backpressure:
  - With out_ready low, bubbles collapse forward.
  - in_ready falls only when all STAGES stages are valid and out_ready = 0.
  - Capacity is STAGES transactions in flight.
- Simultaneous events: on a full pipe with out_ready = 1 and in_valid = 1, the output transfer, every shift, and the input transfer all happen in the same cycle. Nothing is lost or duplicated.
- rst asserted mid-operation: every in-flight transaction is discarded on that edge. No output transfer occurs in the reset cycle or after it.
- Ordering: results leave strictly in acceptance order.

## Structure
- No shared package is required. CHUNK and the stage-index bit slices are localparams derived from WIDTH and STAGES.
- One sub-module: pipe_adder_stage, parameterised by CHUNK and by the width of its pass-through field. Each instance contains:
  - one chunk adder plus its carry register;
  - sum-prefix and operand pass-through registers;
  - the valid bit and its load/unload logic.
- The top instantiates STAGES copies with a generate loop and adds the MSB-carry tap for ovf.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- a=0xFFFF, b=0x0001, cin=0 → after 4 cycles sum=0x0000, cout=1, ovf=0. With cin=1: sum=0x0001, cout=1.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Carry crossing every chunk boundary: a=0x0FFF, b=0x0001 → sum=0x1000. Then 100 back-to-back random vectors with out_ready=1 → one result per cycle, in order, matching a reference model.
- Backpressure: out_ready=0 while 6 inputs are offered.
  - Exactly 4 are accepted, then in_ready=0 and outputs stay stable.
  - Raising out_ready drains the 4 accepted results in order and admits the remaining 2.
- Bubbles: inputs every other cycle, out_ready toggling randomly → no loss or duplication, and the scoreboard is empty at the end.
- rst pulsed for 1 cycle with 3 transactions in flight → out_valid=0 from the next cycle. The next accepted vector appears after exactly 4 cycles.
